// File: rtl/control_pkg.sv
// control_pkg: shared opcodes, datapath function/select codes and the
// sequencer state type used by control_unit.
package control_pkg;

  // Opcodes (IROut[15:10])
  localparam logic [5:0] OP_BRA   = 6'h00;
  localparam logic [5:0] OP_BNE   = 6'h01;
  localparam logic [5:0] OP_BEQ   = 6'h02;
  localparam logic [5:0] OP_LDI   = 6'h03;
  localparam logic [5:0] OP_LDM   = 6'h04;
  localparam logic [5:0] OP_STM   = 6'h05;
  localparam logic [5:0] OP_ADD   = 6'h06;
  localparam logic [5:0] OP_INCAR = 6'h07;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  // RF / ARF function codes
  localparam logic [2:0] FUN_HOLD  = 3'b000;
  localparam logic [2:0] FUN_INC   = 3'b001;
  localparam logic [2:0] FUN_LOAD  = 3'b010;
  localparam logic [2:0] FUN_CLEAR = 3'b011;

  // ALU function codes
  localparam logic [4:0] ALU_PASSA = 5'b10000;
  localparam logic [4:0] ALU_ADD16 = 5'b10100;

  // MuxA/MuxB selects
  localparam logic [1:0] MUX_ALU  = 2'b00;
  localparam logic [1:0] MUX_OUTC = 2'b01;
  localparam logic [1:0] MUX_MEM  = 2'b10;
  localparam logic [1:0] MUX_IMM  = 2'b11;

  // ARF read selects
  localparam logic [1:0] ARF_PC = 2'b00;
  localparam logic [1:0] ARF_SP = 2'b01;
  localparam logic [1:0] ARF_AR = 2'b10;

  // Active-low write enables
  localparam logic [2:0] ARF_EN_NONE = 3'b111;
  localparam logic [2:0] ARF_EN_PC   = 3'b011;
  localparam logic [2:0] ARF_EN_AR   = 3'b101;
  localparam logic [3:0] RF_EN_NONE  = 4'b1111;

  typedef enum logic [1:0] {FETCH_L, FETCH_H, EXEC, HALT} state_t;

  // Active-low enable for register Rx: bit 3 = R1 ... bit 0 = R4.
  function automatic logic [3:0] rf_en(input logic [1:0] rx);
    return ~(4'b1000 >> rx);
  endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: three-cycle fetch/fetch/execute sequencer driving the
// ArithmeticLogicUnitSystem control word.
//   Clock, Reset       : clock, async active-high reset
//   IROut, ALUOutFlag  : instruction register and {Z,C,N,O} flags
//   RF_*/ALU_*/ARF_*/IR_*/Mem_*/Mux*Sel : datapath control word
//   T, Halted, InstrDone : sequence counter and status
module control_unit
  import control_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  T,
  output logic        Halted,
  output logic        InstrDone
);

  state_t state_q, state_d;

  logic [5:0] opcode;
  logic [1:0] rx, ry;
  logic       z_flag;
  logic       unused_bits;

  assign opcode = IROut[15:10];
  assign rx     = IROut[9:8];
  assign ry     = IROut[1:0];
  assign z_flag = ALUOutFlag[3];
  // Immediate byte is routed by the datapath mux, and C/N/O are not decoded here.
  assign unused_bits = ^{IROut[7:2], ALUOutFlag[2:0]};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= FETCH_L;
    else       state_q <= state_d;
  end

  always_comb begin
    // Idle word first; each state overrides only the fields it uses.
    state_d     = state_q;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = FUN_HOLD;
    RF_RegSel   = RF_EN_NONE;
    RF_ScrSel   = RF_EN_NONE;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    ARF_OutCSel = ARF_PC;
    ARF_OutDSel = ARF_PC;
    ARF_FunSel  = FUN_HOLD;
    ARF_RegSel  = ARF_EN_NONE;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    MuxASel     = MUX_ALU;
    MuxBSel     = MUX_ALU;
    MuxCSel     = 1'b0;
    T           = 3'd0;
    Halted      = 1'b0;
    InstrDone   = 1'b0;

    // Reset gates the word so an aborted instruction writes nothing.
    if (!Reset) begin
      unique case (state_q)
        FETCH_L, FETCH_H: begin
          ARF_OutDSel = ARF_PC;
          Mem_CS      = 1'b0;
          IR_Write    = 1'b1;
          IR_LH       = (state_q == FETCH_H);
          ARF_FunSel  = FUN_INC;
          ARF_RegSel  = ARF_EN_PC;
          T           = (state_q == FETCH_H) ? 3'd1 : 3'd0;
          state_d     = (state_q == FETCH_H) ? EXEC : FETCH_H;
        end
        EXEC: begin
          T         = 3'd2;
          InstrDone = 1'b1;
          state_d   = (opcode == OP_HLT) ? HALT : FETCH_L;
          case (opcode)
            OP_BRA, OP_BNE, OP_BEQ: begin
              if ((opcode == OP_BRA) ||
                  (opcode == OP_BNE && !z_flag) ||
                  (opcode == OP_BEQ &&  z_flag)) begin
                MuxBSel    = MUX_IMM;
                ARF_FunSel = FUN_LOAD;
                ARF_RegSel = ARF_EN_PC;
              end
            end
            OP_LDI: begin
              MuxASel   = MUX_IMM;
              RF_FunSel = FUN_LOAD;
              RF_RegSel = rf_en(rx);
            end
            OP_LDM: begin
              ARF_OutDSel = ARF_AR;
              Mem_CS      = 1'b0;
              MuxASel     = MUX_MEM;
              RF_FunSel   = FUN_LOAD;
              RF_RegSel   = rf_en(rx);
            end
            OP_STM: begin
              RF_OutASel  = {1'b0, rx};
              ALU_FunSel  = ALU_PASSA;
              MuxCSel     = 1'b0;
              ARF_OutDSel = ARF_AR;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b1;
            end
            OP_ADD: begin
              RF_OutASel = {1'b0, rx};
              RF_OutBSel = {1'b0, ry};
              ALU_FunSel = ALU_ADD16;
              ALU_WF     = 1'b1;
              MuxASel    = MUX_ALU;
              RF_FunSel  = FUN_LOAD;
              RF_RegSel  = rf_en(rx);
            end
            OP_INCAR: begin
              ARF_FunSel = FUN_INC;
              ARF_RegSel = ARF_EN_AR;
            end
            default: ; // HLT and undefined opcodes: idle word
          endcase
        end
        HALT: begin
          Halted = 1'b1;
        end
        default: state_d = FETCH_L;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_CS, Mem_WR;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  T;
  logic        Halted, InstrDone;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
    .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
    .IR_Write(IR_Write), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .T(T), .Halted(Halted), .InstrDone(InstrDone)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] asel, bsel, rffun;
    logic [3:0] rfreg, scr;
    logic [4:0] alufun;
    logic       wf;
    logic [1:0] csel, dsel;
    logic [2:0] arffun, arfreg;
    logic       lh, irw, cs, wr;
    logic [1:0] ma, mb;
    logic       mc;
    logic [2:0] t;
    logic       halted, done;
  } cw_t;

  cw_t obs;
  assign obs = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
                ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
                ARF_RegSel, IR_LH, IR_Write, Mem_CS, Mem_WR, MuxASel,
                MuxBSel, MuxCSel, T, Halted, InstrDone};

  int errors = 0;
  int checks = 0;
  int ph = 0; // 0 = fetch low, 1 = fetch high, 2 = execute, 3 = halted

  // Reference: what the datapath should be told in a given phase.
  function automatic cw_t model(input int p, input logic [15:0] ir,
                                input logic [3:0] fl, input bit rst);
    cw_t c;
    int op, rx, ry;
    bit take;
    c = '0;
    c.rfreg = 4'hF; c.scr = 4'hF; c.arfreg = 3'h7; c.cs = 1'b1;
    if (rst) return c;
    op = int'(ir[15:10]); rx = int'(ir[9:8]); ry = int'(ir[1:0]);
    if (p == 0 || p == 1) begin
      c.dsel = 2'd0; c.cs = 1'b0; c.irw = 1'b1; c.lh = (p == 1);
      c.arffun = 3'd1; c.arfreg = 3'b011; c.t = (p == 1) ? 3'd1 : 3'd0;
    end else if (p == 2) begin
      c.t = 3'd2; c.done = 1'b1;
      take = (op == 0) || (op == 1 && fl[3] == 1'b0) || (op == 2 && fl[3] == 1'b1);
      if (op <= 2 && take) begin
        c.mb = 2'd3; c.arffun = 3'd2; c.arfreg = 3'b011;
      end
      if (op == 3 || op == 4 || op == 6) begin
        c.rffun = 3'd2;
        c.rfreg = 4'hF & ~(4'd1 << (3 - rx));
        c.ma = (op == 3) ? 2'd3 : (op == 4) ? 2'd2 : 2'd0;
      end
      if (op == 4 || op == 5) begin
        c.dsel = 2'd2; c.cs = 1'b0;
      end
      if (op == 5) begin
        c.asel = 3'(rx); c.alufun = 5'd16; c.wr = 1'b1;
      end
      if (op == 6) begin
        c.asel = 3'(rx); c.bsel = 3'(ry); c.alufun = 5'd20; c.wf = 1'b1;
      end
      if (op == 7) begin
        c.arffun = 3'd1; c.arfreg = 3'b101;
      end
    end else begin
      c.halted = 1'b1;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input cw_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check the decoded word, then advance a clock.
  task automatic cyc(input string tag, input logic [15:0] ir, input logic [3:0] fl);
    IROut = ir; ALUOutFlag = fl;
    #1;
    chk(tag, model(ph, ir, fl, 1'b0));
    @(posedge Clock); #1;
    if (ph == 0) ph = 1;
    else if (ph == 1) ph = 2;
    else if (ph == 2) ph = (ir[15:10] == 6'h3F) ? 3 : 0;
  endtask

  task automatic instr(input string tag, input logic [15:0] ir, input logic [3:0] fl);
    cyc({tag, "_t0"}, 16'($urandom), 4'($urandom));
    cyc({tag, "_t1"}, 16'($urandom), 4'($urandom));
    cyc({tag, "_t2"}, ir, fl);
  endtask

  initial begin
    logic [15:0] ir;
    int op;
    Reset = 1'b1; IROut = 16'h0; ALUOutFlag = 4'h0;
    #1;
    chk("reset_idle", model(0, 16'h0, 4'h0, 1'b1));
    @(posedge Clock); #1;
    Reset = 1'b0; ph = 0;

    instr("ldi",     16'h0C5A, 4'h0);
    instr("add",     16'h1902, 4'h0);
    instr("beq_z0",  16'h0820, 4'h0);
    instr("beq_z1",  16'h0820, 4'h8);
    instr("bne_z0",  16'h0420, 4'h7);
    instr("bne_z1",  16'h0420, 4'hF);
    instr("bra",     16'h0033, 4'h8);
    instr("stm",     16'h1700, 4'h0);
    instr("ldm",     16'h1200, 4'h0);
    instr("incar",   16'h1C00, 4'h0);
    instr("nop",     16'h2000, 4'h0);

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 11));
      if (op > 7) op = int'($urandom_range(8, 62));
      ir = {6'(op), 10'($urandom)};
      instr("rand", ir, 4'($urandom));
    end

    // Reset during the high-byte fetch aborts the instruction at once.
    cyc("abort_t0", 16'h1902, 4'h0);
    IROut = 16'h1902; #1;
    chk("abort_t1", model(1, IROut, 4'h0, 1'b0));
    Reset = 1'b1; #1;
    chk("abort_idle", model(1, IROut, 4'h0, 1'b1));
    @(posedge Clock); #1;
    chk("abort_held", model(1, IROut, 4'h0, 1'b1));
    Reset = 1'b0; ph = 0;
    instr("resume", 16'h0C11, 4'h0);

    // Halt is absorbing until reset.
    instr("hlt", 16'hFC00, 4'h0);
    for (int i = 0; i < 10; i++) cyc("halted", 16'($urandom), 4'($urandom));
    Reset = 1'b1; #1;
    chk("halt_reset", model(0, 16'h0, 4'h0, 1'b1));
    @(posedge Clock); #1;
    Reset = 1'b0; ph = 0;
    instr("after_halt", 16'h1B03, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing control unit that drives every control input of `ArithmeticLogicUnitSystem` and closes the loop through `IROut` and `ALUOutFlag`. It fetches a 16-bit instruction as two bytes from byte-wide memory at PC into the IR, decodes it, and sequences a one-cycle execute step. It sits beside the datapath at the top level as the initiator of the control-word interface; the datapath is the responder.

## Interface
Parameters:
- none. Opcodes and datapath codes are fixed in the shared package.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `IROut`  in  16  instruction register contents from the datapath.
- `ALUOutFlag`  in  4  flags {Z,C,N,O}; bit 3 is Z.
- `RF_OutASel`, `RF_OutBSel`  out  3 each  register-file read selects: 000..011 = R1..R4.
- `RF_FunSel`  out  3  register-file function.
- `RF_RegSel`, `RF_ScrSel`  out  4 each  active-low write enables; bit 3 = R1, bit 0 = R4.
- `ALU_FunSel`  out  5  ALU operation.
- `ALU_WF`  out  1  flag write enable.
- `ARF_OutCSel`, `ARF_OutDSel`  out  2 each  address-register reads: 00 = PC, 01 = SP, 10 = AR.
- `ARF_FunSel`  out  3  address-register-file function.
- `ARF_RegSel`  out  3  active-low enables: bit 2 = PC, bit 1 = AR, bit 0 = SP.
- `IR_LH`  out  1  IR byte select: 0 = low, 1 = high.
- `IR_Write`  out  1  IR load enable.
- `Mem_CS`  out  1  memory chip select, active-low.
- `Mem_WR`  out  1  memory write: 1 = write, 0 = read.
- `MuxASel`, `MuxBSel`  out  2 each  mux selects: 00 = ALUOut, 01 = OutC, 10 = MemOut, 11 = IROut[7:0].
- `MuxCSel`  out  1  memory write-data mux: 0 = low byte, 1 = high byte.
- `T`  out  3  sequence counter, for debug.
- `Halted`  out  1  high while in HALT.
- `InstrDone`  out  1  one-cycle pulse on the final cycle of each instruction.

## Operation
- Idle control word: all RegSel/ScrSel = all ones; `IR_Write` = 0; `Mem_CS` = 1; `Mem_WR` = 0; `ALU_WF` = 0; all selects and FunSels = 0.
  - The idle word is asserted in every cycle and field not named below.
- Function codes:
  - RF/ARF: HOLD = 000, INC = 001, LOAD = 010, CLEAR = 011.
  - ALU: PASSA = 5'b10000, ADD16 = 5'b10100.
- Fields: opcode = `IROut[15:10]`; Rx = `IROut[9:8]`; Ry = `IROut[1:0]`; imm = `IROut[7:0]`.
- T0, fetch low byte:
  - `ARF_OutDSel` = PC, `Mem_CS` = 0, `IR_Write` = 1, `IR_LH` = 0.
  - PC INC.
- T1, fetch high byte: same as T0 with `IR_LH` = 1.
- T2, execute (opcode in hex):
  - 00 BRA: `MuxBSel` = 11, ARF LOAD, PC enabled.
  - 01 BNE: as BRA only if Z = 0; otherwise idle.
  - 02 BEQ: as BRA only if Z = 1; otherwise idle.
  - 03 LDI: `MuxASel` = 11, RF LOAD, Rx enabled.
  - 04 LDM: `ARF_OutDSel` = AR, `Mem_CS` = 0, `MuxASel` = 10, RF LOAD, Rx enabled.
  - 05 STM: `RF_OutASel` = Rx, ALU PASSA, `MuxCSel` = 0, `ARF_OutDSel` = AR, `Mem_CS` = 0, `Mem_WR` = 1.
  - 06 ADD: `RF_OutASel` = Rx, `RF_OutBSel` = Ry, ALU ADD16, `ALU_WF` = 1, `MuxASel` = 00, RF LOAD, Rx enabled.
  - 07 INCAR: ARF INC, AR enabled.
  - 3F HLT: enter HALT.
  - Any other opcode: idle word (NOP).
- States:
  - FETCH_L → FETCH_H → EXEC → FETCH_L.
  - EXEC → HALT on HLT. HALT is absorbing, drives the idle word, `Halted` = 1, and exits only on `Reset`.

## Timing
- Reset (asynchronous, immediate): state FETCH_L, `T` = 0, `Halted` = 0, `InstrDone` = 0, idle control word on all outputs.
  - PC is not cleared by this block; the datapath reset owns PC.
- Every instruction takes exactly 3 cycles: T = 0, 1, 2. `InstrDone` = 1 during T2, including for HLT and NOP.
- Control outputs are decoded combinationally from state, `T` and `IROut`. At T2, `IROut` reflects both bytes latched at the T0 and T1 edges.
- Branch condition samples `ALUOutFlag` combinationally at T2; flags written by a preceding ADD's T2 edge are visible.
- `Reset` asserted mid-instruction aborts it; no partial writes occur after the reset edge.

## Structure
- Package `control_pkg`: opcode localparams; RF/ARF/ALU function codes; mux-select codes; register-select one-hot-low constants; state enum {FETCH_L, FETCH_H, EXEC, HALT}.
- Single module; no sub-module. Decode is one combinational `always` block with the idle word as its default assignment.

## Test plan
- Reset, then `IROut` = 0x0C5A in T2 (LDI R1,0x5A) → T0 shows `Mem_CS` = 0, `IR_LH` = 0; T2 shows `MuxASel` = 11, `RF_RegSel` = 0111, `RF_FunSel` = 010; `InstrDone` = 1.
- ADD R2,R3 (`IROut` = 0x1902) at T2 → `RF_OutASel` = 001, `RF_OutBSel` = 010, `ALU_FunSel` = 10100, `ALU_WF` = 1, `RF_RegSel` = 1011.
- BEQ 0x20 (0x0820) with Z = 0 → idle word at T2; with Z = 1 → `MuxBSel` = 11, `ARF_RegSel` = 011, `ARF_FunSel` = 010.
- STM R4 (0x1700) → T2: `Mem_CS` = 0, `Mem_WR` = 1, `ARF_OutDSel` = 10, `RF_OutASel` = 011, `ALU_FunSel` = 10000.
- HLT (0xFC00) → `Halted` = 1 from the next cycle; 10 further cycles show the idle word and `T` frozen at 0; `Reset` → FETCH_L, `Halted` = 0.
- `Reset` pulsed during T1 → outputs go idle immediately; after release, T0 fetch with `IR_LH` = 0 resumes.
